serial_adder: RTL and testbench

//  Multi-cycle, bit-serial two's-complement adder; the addition counterpart of the ALU subtractor.

---
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: one full-adder cell, one operand bit per clock, LSB first.
// Produces the sign-extended SIZE+1-bit sum and the SIZE-bit signed overflow flag.
//
//   state  | meaning
//   S_IDLE | ready for start; operands latched on the accepting edge
//   S_RUN  | one bit pair summed per clock, bit 0 first
//   S_DONE | result/overflow just written; done pulses for this cycle
module serial_adder #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            ready,
    output logic            done,
    output logic            overflow,
    output logic [SIZE:0]   result
);

    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SIZE-1:0] a_sh, b_sh;
    logic [SIZE-2:0] sum_sh;
    logic [CW-1:0]   count;
    logic            carry;

    logic            s, cout, last_bit;
    logic [SIZE-1:0] sum_nxt;

    assign s        = a_sh[0] ^ b_sh[0] ^ carry;
    assign cout     = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign sum_nxt  = {s, sum_sh};
    assign last_bit = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // On the MSB edge, carry still holds the carry into the MSB, so the overflow is carry ^ cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            count    <= '0;
            carry    <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= 1'b0;
                        count <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_nxt[SIZE-1:1];
                    carry  <= cout;
                    count  <= count + CW'(1);
                    if (last_bit) begin
                        result   <= {a_sh[0] ^ b_sh[0] ^ cout, sum_nxt};
                        overflow <= carry ^ cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: a SIZE=4 instance for the directed cases and a SIZE=8 instance for random
// operands, both checked against plain signed arithmetic.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       ready4, done4, ovf4;
    logic [4:0] res4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ready8, done8, ovf8;
    logic [8:0] res8;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder #(.SIZE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .ready(ready4), .done(done4), .overflow(ovf4), .result(res4)
    );

    serial_adder #(.SIZE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .done(done8), .overflow(ovf8), .result(res8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic rdy(input bit big);
        return big ? ready8 : ready4;
    endfunction

    function automatic logic dn(input bit big);
        return big ? done8 : done4;
    endfunction

    function automatic logic [8:0] res(input bit big);
        return big ? res8 : {4'b0, res4};
    endfunction

    function automatic logic ovf(input bit big);
        return big ? ovf8 : ovf4;
    endfunction

    task automatic drive(input bit big, input logic st, input logic [7:0] x, input logic [7:0] y);
        if (big) begin
            start8 = st; a8 = x; b8 = y;
        end else begin
            start4 = st; a4 = x[3:0]; b4 = y[3:0];
        end
    endtask

    // Reference: exact signed sum, overflow when it leaves the SIZE-bit signed range.
    task automatic model(input bit big, input logic [7:0] x, input logic [7:0] y,
                         output logic [8:0] exp_r, output logic exp_o);
        int s;
        if (big) begin
            s     = int'($signed(x)) + int'($signed(y));
            exp_o = (s < -128) || (s > 127);
            exp_r = s[8:0];
        end else begin
            s     = int'($signed(x[3:0])) + int'($signed(y[3:0]));
            exp_o = (s < -8) || (s > 7);
            exp_r = {4'b0, s[4:0]};
        end
    endtask

    // One operation; with hold=1 start stays high and the operands churn until the DONE->IDLE edge.
    task automatic op(input bit big, input logic [7:0] x, input logic [7:0] y, input bit hold);
        int sz;
        logic [8:0] exp_r;
        logic exp_o;
        sz = big ? 8 : 4;
        model(big, x, y, exp_r, exp_o);
        @(negedge clk);
        chk("ready_idle", 32'(rdy(big)), 32'd1);
        drive(big, 1'b1, x, y);
        @(posedge clk); #1;
        if (hold) drive(big, 1'b1, 8'($urandom), 8'($urandom));
        else      drive(big, 1'b0, x, y);
        for (int i = 1; i < sz; i++) begin
            @(posedge clk); #1;
            chk("done_early", 32'(dn(big)), 32'd0);
            chk("ready_run", 32'(rdy(big)), 32'd0);
            if (hold) drive(big, 1'b1, 8'($urandom), 8'($urandom));
        end
        @(posedge clk); #1;
        chk("done_pulse", 32'(dn(big)), 32'd1);
        chk("ready_done", 32'(rdy(big)), 32'd0);
        chk("result", 32'(res(big)), 32'(exp_r));
        chk("overflow", 32'(ovf(big)), 32'(exp_o));
        @(posedge clk); #1;
        drive(big, 1'b0, x, y);
        chk("done_width", 32'(dn(big)), 32'd0);
        chk("ready_back", 32'(rdy(big)), 32'd1);
        chk("result_hold", 32'(res(big)), 32'(exp_r));
    endtask

    initial begin
        logic [8:0] er;
        logic eo;
        #2;
        chk("rst_ready4", 32'(ready4), 32'd1);
        chk("rst_done4", 32'(done4), 32'd0);
        chk("rst_result4", 32'(res4), 32'd0);
        chk("rst_ovf4", 32'(ovf4), 32'd0);
        chk("rst_ready8", 32'(ready8), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        op(1'b0, 8'h0, 8'h0, 1'b0);
        op(1'b0, 8'h5, 8'h6, 1'b0);
        op(1'b0, 8'h7, 8'h8, 1'b0);
        op(1'b0, 8'hB, 8'hC, 1'b0);
        op(1'b0, 8'hF, 8'hF, 1'b0);

        // start held high with operands changing during RUN: one completion, first operands only.
        op(1'b0, 8'h3, 8'h4, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_requeue", 32'(done4), 32'd0);
            chk("held_result", 32'(res4), 32'h07);
        end

        // Reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h6, 8'h7);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h6, 8'h7);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_result", 32'(res4), 32'd0);
        chk("abort_ovf", 32'(ovf4), 32'd0);
        chk("abort_ready", 32'(ready4), 32'd1);
        chk("abort_done", 32'(done4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done4), 32'd0);
        end
        op(1'b0, 8'h6, 8'h7, 1'b0);

        for (int i = 0; i < 20; i++) op(1'b0, 8'($urandom), 8'($urandom), 1'b0);

        op(1'b1, 8'h7F, 8'h01, 1'b0);
        op(1'b1, 8'h80, 8'h80, 1'b0);
        op(1'b1, 8'h80, 8'h7F, 1'b0);
        op(1'b1, 8'hFF, 8'h01, 1'b0);
        for (int i = 0; i < 200; i++) op(1'b1, 8'($urandom), 8'($urandom), 1'b0);

        model(1'b1, 8'h40, 8'h40, er, eo);
        op(1'b1, 8'h40, 8'h40, 1'b1);
        @(posedge clk); #1;
        chk("held_result8", 32'(res8), 32'(er));
        chk("held_ovf8", 32'(ovf8), 32'(eo));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
